full_add: RTL and testbench
===========================

// Module: full_add
//
// PURPOSE
//   Unsigned WIDTH-bit adder with carry-in and carry-out: {c_out, sum} = a + b + c_in.
//   Datapath arithmetic leaf used wherever a registered add-with-carry is needed.
//   Internally built from per-bit full-adder cells with 4-bit carry-lookahead groups.
//   Groups are chained by ripple between them. The result is registered by default.
//
// PARAMETERS
//   WIDTH    4   operand/sum width in bits; legal range 1..64.
//   REG_OUT  1   1: sum/c_out registered (1-cycle latency); 0: purely combinational.
//
// PORTS
//   clk    in   1      rising-edge clock.
//   rst_n  in   1      asynchronous active-low reset.
//   a      in   WIDTH  operand A, unsigned.
//   b      in   WIDTH  operand B, unsigned.
//   c_in   in   1      carry-in, weight 1.
//   sum    out  WIDTH  low WIDTH bits of a + b + c_in.
//   c_out  out  1      carry out of bit WIDTH-1.
//
// BEHAVIOUR
//   - Arithmetic: the full (WIDTH+1)-bit result is a + b + c_in. The result never wraps
//     silently: overflow goes to c_out. Max case: a = b = 2^WIDTH-1 with c_in = 1 gives
//     sum = all ones and c_out = 1.
//   - Per-bit cell: s_i = a_i ^ b_i ^ c_i; g_i = a_i & b_i; p_i = a_i ^ b_i.
//   - Carry-lookahead group of 4 bits:
//     - c_{i+1} = g_i | (p_i & c_i), computed in flattened lookahead form.
//     - Each group outputs group carry G | (P & c_group_in).
//     - Groups ripple from LSB to MSB.
//     - If WIDTH is not a multiple of 4, the top group is partial with the same equations.
//   - REG_OUT = 1:
//     - a, b and c_in are sampled combinationally. The result is captured into sum/c_out
//       on every rising clk edge; there is no enable.
//     - Latency is exactly 1 cycle: inputs stable before edge N appear on the outputs
//       after edge N.
//     - Throughput is one new result per cycle.
//     - rst_n low asynchronously forces sum = 0 and c_out = 0, independent of clk.
//       The outputs hold 0 while rst_n is low.
//     - The first capture happens on the first rising edge after rst_n deasserts.
//     - Reset asserted mid-stream discards the in-flight result immediately.
//   - REG_OUT = 0:
//     - sum/c_out follow the inputs combinationally with zero latency.
//     - clk and rst_n are unused; no state.
//   - No X propagation guarantees beyond standard operator semantics. Inputs are assumed
//     known at the sampling edge.
//
// TESTING  (WIDTH=4, REG_OUT=1 unless noted)
//   1. Reset: hold rst_n=0 across edges with a=F, b=F, c_in=1 -> sum=0, c_out=0 throughout.
//      Release rst_n; after the next edge -> sum=F, c_out=1.
//   2. Basic: a=3, b=4, c_in=0 -> after 1 edge sum=7, c_out=0.
//      Then c_in=1 -> next edge sum=8, c_out=0.
//   3. Carry out: a=9, b=8, c_in=1 -> sum=2, c_out=1.
//      a=F, b=1, c_in=0 -> sum=0, c_out=1 (full wrap).
//   4. Latency and back-to-back: apply 5 random vector sets on consecutive edges.
//      Each result appears exactly one edge later and matches the {c_out,sum} model.
//   5. Async reset mid-operation: pull rst_n low between edges while sum=7.
//      sum and c_out go to 0 immediately, without waiting for clk.
//   6. Exhaustive: REG_OUT=0 and WIDTH=4, all 512 combinations of a, b, c_in.
//      Outputs match the model with zero latency. Also run WIDTH=6 (partial group) with
//      random vectors.

Source files
------------

// File: rtl/full_add_if.sv
// full_add_if: operand/result bundle for the add-with-carry leaf.
interface full_add_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    modport master (output a, b, c_in, input sum, c_out);
    modport slave  (input a, b, c_in, output sum, c_out);
endinterface

// File: rtl/full_add.sv
// full_add: WIDTH-bit add-with-carry from 4-bit lookahead groups rippled LSB to MSB, optionally registered.
module full_add #(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    full_add_if.slave bus
);
    localparam int NG = (WIDTH + 3) / 4;
    localparam int WP = 4 * NG;

    logic [WIDTH-1:0] g, p, sum_c;
    logic [WP-1:0]    gx, px, sx;
    logic             cy;

    // Flattened carry out of bit j of a group: OR of every generate term propagated up, plus ci.
    function automatic logic la(input logic [3:0] gg, input logic [3:0] pp, input logic ci, input int j);
        logic r, t;
        r = ci;
        for (int k = 0; k <= j; k++) r = r & pp[k];
        for (int i = 0; i <= j; i++) begin
            t = gg[i];
            for (int k = i + 1; k <= j; k++) t = t & pp[k];
            r = r | t;
        end
        return r;
    endfunction

    function automatic logic pa(input logic [3:0] pp, input int j);
        logic r;
        r = 1'b1;
        for (int k = 0; k <= j; k++) r = r & pp[k];
        return r;
    endfunction

    function automatic int top(input int k);
        return (WIDTH - 4 * k < 4) ? WIDTH - 4 * k - 1 : 3;
    endfunction

    always_comb begin
        g  = bus.a & bus.b;
        p  = bus.a ^ bus.b;
        gx = WP'(g);
        px = WP'(p);
        sx = '0;
        cy = bus.c_in;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < 4; j++)
                sx[4*k+j] = px[4*k+j] ^ (j == 0 ? cy : la(gx[4*k +: 4], px[4*k +: 4], cy, j - 1));
            cy = la(gx[4*k +: 4], px[4*k +: 4], 1'b0, top(k)) | (pa(px[4*k +: 4], top(k)) & cy);
        end
        sum_c = sx[WIDTH-1:0];
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    bus.sum   <= '0;
                    bus.c_out <= 1'b0;
                end else begin
                    bus.sum   <= sum_c;
                    bus.c_out <= cy;
                end
        end else begin : g_comb
            assign bus.sum   = sum_c;
            assign bus.c_out = cy;
        end
    endgenerate
endmodule

// File: tb/tb_full_add.sv
// tb_full_add: random and directed checks of registered/combinational adders at WIDTH 4 and 6.
module tb_full_add;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4;
    logic       c4;
    logic [5:0] a6, b6;
    logic       c6;
    int         checks = 0;
    int         failures = 0;
    int         e4r = 0;
    int         e6r = 0;

    full_add_if #(.WIDTH(4)) if4r ();
    full_add_if #(.WIDTH(4)) if4c ();
    full_add_if #(.WIDTH(6)) if6r ();
    full_add_if #(.WIDTH(6)) if6c ();

    assign if4r.a = a4; assign if4r.b = b4; assign if4r.c_in = c4;
    assign if4c.a = a4; assign if4c.b = b4; assign if4c.c_in = c4;
    assign if6r.a = a6; assign if6r.b = b6; assign if6r.c_in = c6;
    assign if6c.a = a6; assign if6c.b = b6; assign if6c.c_in = c6;

    full_add #(.WIDTH(4), .REG_OUT(1'b1)) u4r (.clk(clk), .rst_n(rst_n), .bus(if4r));
    full_add #(.WIDTH(4), .REG_OUT(1'b0)) u4c (.clk(clk), .rst_n(rst_n), .bus(if4c));
    full_add #(.WIDTH(6), .REG_OUT(1'b1)) u6r (.clk(clk), .rst_n(rst_n), .bus(if6r));
    full_add #(.WIDTH(6), .REG_OUT(1'b0)) u6c (.clk(clk), .rst_n(rst_n), .bus(if6c));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: registered result is last sampled a+b+c_in, zero under reset.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e4r = 0;
            e6r = 0;
        end else begin
            e4r = int'(a4) + int'(b4) + int'(c4);
            e6r = int'(a6) + int'(b6) + int'(c6);
        end

    always @(negedge clk) begin
        check("reg4",  {if4r.c_out, if4r.sum}, e4r);
        check("comb4", {if4c.c_out, if4c.sum}, int'(a4) + int'(b4) + int'(c4));
        check("reg6",  {if6r.c_out, if6r.sum}, e6r);
        check("comb6", {if6c.c_out, if6c.sum}, int'(a6) + int'(b6) + int'(c6));
    end

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(posedge clk);
        #2;
        a4 = a; b4 = b; c4 = c;
        a6 = 6'($urandom); b6 = 6'($urandom); c6 = 1'($urandom);
    endtask

    task automatic settle;
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst_n = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        a6 = 6'h3F; b6 = 6'h3F; c6 = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_hold4", {if4r.c_out, if4r.sum}, 32'h0);
        check("rst_hold6", {if6r.c_out, if6r.sum}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        settle();
        check("rst_rel4", {if4r.c_out, if4r.sum}, 32'h1F);
        check("max6",     {if6r.c_out, if6r.sum}, 32'h7F);
        apply(4'h3, 4'h4, 1'b0);
        #1 check("comb_3p4", {if4c.c_out, if4c.sum}, 32'h07);
        settle();
        check("basic7", {if4r.c_out, if4r.sum}, 32'h07);
        apply(4'h3, 4'h4, 1'b1);
        settle();
        check("basic8", {if4r.c_out, if4r.sum}, 32'h08);
        apply(4'h9, 4'h8, 1'b1);
        settle();
        check("carry12", {if4r.c_out, if4r.sum}, 32'h12);
        apply(4'hF, 4'h1, 1'b0);
        settle();
        check("wrap10", {if4r.c_out, if4r.sum}, 32'h10);
        apply(4'h3, 4'h4, 1'b0);
        settle();
        check("pre_async", {if4r.c_out, if4r.sum}, 32'h07);
        rst_n = 1'b0;
        #1;
        check("async4", {if4r.c_out, if4r.sum}, 32'h0);
        check("async6", {if6r.c_out, if6r.sum}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) apply(4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 512; i++) apply(4'(i), 4'(i >> 4), 1'(i >> 8));
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
